// File: rtl/mips_ctrl_pkg.sv
// Shared constants and types for the MIPS multicycle control path.
// Holds the FSM state encodings, opcode values, ALU operation classes,
// the decoded instruction class and the datapath control bundle.
package mips_ctrl_pkg;

  // FSM state encodings (also exported on the debug 'state' port)
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  // Opcodes, instr[31:26]
  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_J    = 6'd2;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW   = 6'd43;

  // ALU operation classes
  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  typedef enum logic [2:0] {
    IC_R, IC_LW, IC_SW, IC_BEQ, IC_J, IC_ADDI, IC_BAD
  } iclass_t;

  typedef struct packed {
    iclass_t cls;
    logic    legal;
  } dec_t;

  // Datapath control bundle; field order is the packed bit order (MSB first)
  typedef struct packed {
    logic pc_write;
    logic ir_write;
    logic reg_write;
    logic reg_dst;
    logic alu_src;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic jump;
    logic branch_taken;
  } ctl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: opcode -> instruction class + legal flag.
// Shared between the multicycle FSM and the single-cycle datapath.
// Ports:
//   opcode  in   6  instr[31:26]
//   dec     out     {cls, legal}
module ctrl_decode
  import mips_ctrl_pkg::*;
#(
  parameter int EN_ADDI = 1
) (
  input  logic [5:0] opcode,
  output dec_t       dec
);

  always_comb begin
    dec.cls   = IC_BAD;
    dec.legal = 1'b1;
    case (opcode)
      OP_R:    dec.cls = IC_R;
      OP_LW:   dec.cls = IC_LW;
      OP_SW:   dec.cls = IC_SW;
      OP_BEQ:  dec.cls = IC_BEQ;
      OP_J:    dec.cls = IC_J;
      OP_ADDI: dec.cls = (EN_ADDI != 0) ? IC_ADDI : IC_BAD;
      default: dec.cls = IC_BAD;
    endcase
    if (dec.cls == IC_BAD) dec.legal = 1'b0;
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM.
// IDLE -> FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> IDLE, with a sticky
// ERR state for illegal opcodes and memory waits that run too long.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   instr             current instruction (opcode = instr[31:26])
//   instr_valid       fetch request, looked at only in IDLE
//   mem_ready         memory completion, looked at in FETCH and MEM
//   zero              ALU zero flag, looked at in EXEC (BEQ)
//   pc_write..branch_taken, aluop   datapath controls
//   busy              high outside IDLE
//   illegal, timeout  sticky error flags
//   state             current state encoding (debug)
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int ALUOP_W     = 2,
  parameter int MEM_TIMEOUT = 15,
  parameter int EN_ADDI     = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        instr,
  input  logic               instr_valid,
  input  logic               mem_ready,
  input  logic               zero,
  output logic               pc_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               alu_src,
  output logic               mem_read,
  output logic               mem_write,
  output logic               mem_to_reg,
  output logic               jump,
  output logic               branch_taken,
  output logic [ALUOP_W-1:0] aluop,
  output logic               busy,
  output logic               illegal,
  output logic               timeout,
  output logic [2:0]         state
);

  // Last wait cycle index; mem_ready on this cycle still completes normally
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] wait_q;
  logic [5:0] op_q;
  logic       illegal_q, timeout_q;
  logic [5:0] dec_op;
  dec_t       dec;
  logic       waiting, wait_hit;
  ctl_t       ctl, ctl_o;
  logic [1:0] aluop_raw;
  logic       unused_instr;

  assign unused_instr = ^instr[25:0];

  // In DECODE the live opcode is classified (it is latched on the same edge);
  // every later state works from the latched copy.
  assign dec_op = (state_q == S_DECODE) ? instr[31:26] : op_q;

  ctrl_decode #(.EN_ADDI(EN_ADDI)) u_dec (
    .opcode (dec_op),
    .dec    (dec)
  );

  assign waiting  = (state_q == S_FETCH) || (state_q == S_MEM);
  assign wait_hit = (wait_q == WAIT_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (instr_valid) state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
                else if (wait_hit) state_d = S_ERR;
      S_DECODE: state_d = dec.legal ? S_EXEC : S_ERR;
      S_EXEC: begin
        case (dec.cls)
          IC_R, IC_ADDI: state_d = S_WB;
          IC_LW, IC_SW:  state_d = S_MEM;
          default:       state_d = S_IDLE;
        endcase
      end
      S_MEM:    if (mem_ready) state_d = (dec.cls == IC_LW) ? S_WB : S_IDLE;
                else if (wait_hit) state_d = S_ERR;
      S_WB:     state_d = S_IDLE;
      S_ERR:    state_d = S_ERR;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      op_q      <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= instr[31:26];
      // Held at zero outside the memory states, so it starts at zero on entry
      if (!waiting)        wait_q <= '0;
      else if (!mem_ready) wait_q <= wait_q + 8'd1;
      if (state_q == S_DECODE && !dec.legal) illegal_q <= 1'b1;
      if (waiting && !mem_ready && wait_hit) timeout_q <= 1'b1;
    end
  end

  // Moore decode of the state, qualified by the sampled inputs where needed
  always_comb begin
    ctl       = '0;
    aluop_raw = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        ctl.mem_read = 1'b1;
        ctl.ir_write = mem_ready;
        ctl.pc_write = mem_ready;
      end
      S_EXEC: begin
        ctl.alu_src = (dec.cls == IC_LW) || (dec.cls == IC_SW) ||
                      (dec.cls == IC_ADDI);
        case (dec.cls)
          IC_R:    aluop_raw = ALU_FUNCT;
          IC_BEQ:  aluop_raw = ALU_SUB;
          default: aluop_raw = ALU_ADD;
        endcase
        if (dec.cls == IC_BEQ) begin
          ctl.branch_taken = zero;
          ctl.pc_write     = zero;
        end
        if (dec.cls == IC_J) begin
          ctl.jump     = 1'b1;
          ctl.pc_write = 1'b1;
        end
      end
      S_MEM: begin
        ctl.mem_read  = (dec.cls == IC_LW);
        ctl.mem_write = (dec.cls == IC_SW);
      end
      S_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.reg_dst    = (dec.cls == IC_R);
        ctl.mem_to_reg = (dec.cls == IC_LW);
      end
      default: ctl = '0;
    endcase
  end

  // Outputs are forced quiet while rst is high so nothing toggles (or shows X
  // before the first reset edge) regardless of the register contents.
  assign ctl_o = rst ? '0 : ctl;

  assign pc_write     = ctl_o.pc_write;
  assign ir_write     = ctl_o.ir_write;
  assign reg_write    = ctl_o.reg_write;
  assign reg_dst      = ctl_o.reg_dst;
  assign alu_src      = ctl_o.alu_src;
  assign mem_read     = ctl_o.mem_read;
  assign mem_write    = ctl_o.mem_write;
  assign mem_to_reg   = ctl_o.mem_to_reg;
  assign jump         = ctl_o.jump;
  assign branch_taken = ctl_o.branch_taken;
  assign aluop        = rst ? '0 : ALUOP_W'(aluop_raw);
  assign busy         = !rst && (state_q != S_IDLE);
  assign illegal      = !rst && illegal_q;
  assign timeout      = !rst && timeout_q;
  assign state        = rst ? S_IDLE : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class
// through the FSM cycle by cycle against hand-written expected controls.
// A second instance with ADDI disabled checks the illegal-ADDI path.
module tb_multicycle_control;

  // ctl bit positions: {pc_write, ir_write, reg_write, reg_dst, alu_src,
  //                     mem_read, mem_write, mem_to_reg, jump, branch_taken}
  localparam logic [9:0] PCW  = 10'h200, IRW = 10'h100, RW  = 10'h080,
                         RDST = 10'h040, ALUS = 10'h020, MR = 10'h010,
                         MW   = 10'h008, M2R = 10'h004, JMP = 10'h002,
                         BT   = 10'h001;

  logic        clk = 1'b0;
  logic        rst, instr_valid, mem_ready, zero;
  logic [31:0] instr;
  logic        pc_write, ir_write, reg_write, reg_dst, alu_src, mem_read,
               mem_write, mem_to_reg, jump, branch_taken, busy, illegal, timeout;
  logic [1:0]  aluop;
  logic [2:0]  state;
  logic        d2_pc_write, d2_ir_write, d2_reg_write, d2_reg_dst, d2_alu_src,
               d2_mem_read, d2_mem_write, d2_mem_to_reg, d2_jump,
               d2_branch_taken, d2_busy, d2_illegal, d2_timeout;
  logic [1:0]  d2_aluop;
  logic [2:0]  d2_state;
  logic [9:0]  ctl;
  int          nvec = 0, nmis = 0;

  always #5 clk = ~clk;

  assign ctl = {pc_write, ir_write, reg_write, reg_dst, alu_src,
                mem_read, mem_write, mem_to_reg, jump, branch_taken};

  multicycle_control #(.ALUOP_W(2), .MEM_TIMEOUT(15), .EN_ADDI(1)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .mem_ready(mem_ready), .zero(zero), .pc_write(pc_write),
    .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .alu_src(alu_src), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .jump(jump), .branch_taken(branch_taken),
    .aluop(aluop), .busy(busy), .illegal(illegal), .timeout(timeout),
    .state(state)
  );

  multicycle_control #(.ALUOP_W(2), .MEM_TIMEOUT(15), .EN_ADDI(0)) dut_na (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .mem_ready(mem_ready), .zero(zero), .pc_write(d2_pc_write),
    .ir_write(d2_ir_write), .reg_write(d2_reg_write), .reg_dst(d2_reg_dst),
    .alu_src(d2_alu_src), .mem_read(d2_mem_read), .mem_write(d2_mem_write),
    .mem_to_reg(d2_mem_to_reg), .jump(d2_jump),
    .branch_taken(d2_branch_taken), .aluop(d2_aluop), .busy(d2_busy),
    .illegal(d2_illegal), .timeout(d2_timeout), .state(d2_state)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Check the current cycle's state/controls/aluop/busy, then advance one edge
  task automatic step(input string tag, input logic [2:0] st,
                      input logic [9:0] c, input logic [1:0] ao);
    #1;
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".ctl"},   32'(ctl),   32'(c));
    chk({tag, ".aluop"}, 32'(aluop), 32'(ao));
    chk({tag, ".busy"},  32'(busy),  32'(st != 3'd0));
    tick();
  endtask

  // Reset pulse: outputs must be quiet while rst is high, flags clear after
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    chk({tag, ".rst_state"}, 32'(state), 32'd0);
    chk({tag, ".rst_ctl"},   32'(ctl),   32'd0);
    chk({tag, ".rst_busy"},  32'(busy),  32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk({tag, ".post_state"},   32'(state),   32'd0);
    chk({tag, ".post_illegal"}, 32'(illegal), 32'd0);
    chk({tag, ".post_timeout"}, 32'(timeout), 32'd0);
    chk({tag, ".post_ctl"},     32'(ctl),     32'd0);
  endtask

  function automatic logic [31:0] op(input logic [5:0] o);
    return {o, 26'h0};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; instr_valid = 1'b0; mem_ready = 1'b0; zero = 1'b0;
    instr = '0;
    tick(); tick();
    do_reset("init");

    // LW, memory always ready: 0,1,2,3,4,5,0
    instr = op(6'd35); instr_valid = 1'b1; mem_ready = 1'b1;
    step("lw_idle", 3'd0, 10'h0, 2'd0);
    instr_valid = 1'b0;
    step("lw_fetch", 3'd1, MR | IRW | PCW, 2'd0);
    step("lw_dec",   3'd2, 10'h0, 2'd0);
    step("lw_exec",  3'd3, ALUS, 2'd0);
    step("lw_mem",   3'd4, MR, 2'd0);
    step("lw_wb",    3'd5, RW | M2R, 2'd0);
    step("lw_done",  3'd0, 10'h0, 2'd0);

    // BEQ taken, then not taken
    instr = op(6'd4); zero = 1'b1; instr_valid = 1'b1;
    step("beq1_idle", 3'd0, 10'h0, 2'd0);
    instr_valid = 1'b0;
    step("beq1_fetch", 3'd1, MR | IRW | PCW, 2'd0);
    step("beq1_dec",   3'd2, 10'h0, 2'd0);
    step("beq1_exec",  3'd3, PCW | BT, 2'd1);
    zero = 1'b0; instr_valid = 1'b1;
    step("beq0_idle", 3'd0, 10'h0, 2'd0);
    instr_valid = 1'b0;
    step("beq0_fetch", 3'd1, MR | IRW | PCW, 2'd0);
    step("beq0_dec",   3'd2, 10'h0, 2'd0);
    step("beq0_exec",  3'd3, 10'h0, 2'd1);
    step("beq0_done",  3'd0, 10'h0, 2'd0);

    // J
    instr = op(6'd2); instr_valid = 1'b1;
    step("j_idle", 3'd0, 10'h0, 2'd0);
    instr_valid = 1'b0;
    step("j_fetch", 3'd1, MR | IRW | PCW, 2'd0);
    step("j_dec",   3'd2, 10'h0, 2'd0);
    step("j_exec",  3'd3, JMP | PCW, 2'd0);

    // R-type
    instr = op(6'd0) | 32'h0000_0020; instr_valid = 1'b1;
    step("r_idle", 3'd0, 10'h0, 2'd0);
    instr_valid = 1'b0;
    step("r_fetch", 3'd1, MR | IRW | PCW, 2'd0);
    step("r_dec",   3'd2, 10'h0, 2'd0);
    step("r_exec",  3'd3, 10'h0, 2'd2);
    step("r_wb",    3'd5, RW | RDST, 2'd0);
    step("r_done",  3'd0, 10'h0, 2'd0);

    // ADDI: legal on dut, illegal on the EN_ADDI=0 instance
    instr = op(6'd8); instr_valid = 1'b1;
    step("addi_idle", 3'd0, 10'h0, 2'd0);
    instr_valid = 1'b0;
    step("addi_fetch", 3'd1, MR | IRW | PCW, 2'd0);
    step("addi_dec",   3'd2, 10'h0, 2'd0);
    chk("addi_na.state",   32'(d2_state),   32'd6);
    chk("addi_na.illegal", 32'(d2_illegal), 32'd1);
    chk("addi_na.busy",    32'(d2_busy),    32'd1);
    chk("addi.illegal",    32'(illegal),    32'd0);
    step("addi_exec", 3'd3, ALUS, 2'd0);
    step("addi_wb",   3'd5, RW, 2'd0);
    step("addi_done", 3'd0, 10'h0, 2'd0);
    chk("addi_na.stuck", 32'(d2_state), 32'd6);
    do_reset("addi_rst");

    // SW with mem_ready low for 3 MEM cycles
    instr = op(6'd43); instr_valid = 1'b1; mem_ready = 1'b1;
    step("sw_idle", 3'd0, 10'h0, 2'd0);
    instr_valid = 1'b0;
    step("sw_fetch", 3'd1, MR | IRW | PCW, 2'd0);
    step("sw_dec",   3'd2, 10'h0, 2'd0);
    step("sw_exec",  3'd3, ALUS, 2'd0);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("sw_memwait", 3'd4, MW, 2'd0);
    mem_ready = 1'b1;
    step("sw_memdone", 3'd4, MW, 2'd0);
    step("sw_done",    3'd0, 10'h0, 2'd0);
    chk("sw.timeout", 32'(timeout), 32'd0);

    // Illegal opcode 63
    instr = op(6'd63); instr_valid = 1'b1;
    step("ill_idle", 3'd0, 10'h0, 2'd0);
    instr_valid = 1'b0;
    step("ill_fetch", 3'd1, MR | IRW | PCW, 2'd0);
    step("ill_dec",   3'd2, 10'h0, 2'd0);
    chk("ill.illegal", 32'(illegal), 32'd1);
    instr_valid = 1'b1;
    step("ill_err0", 3'd6, 10'h0, 2'd0);
    step("ill_err1", 3'd6, 10'h0, 2'd0);
    instr_valid = 1'b0;
    do_reset("ill_rst");

    // mem_ready on the 15th wait cycle still completes the fetch
    instr = op(6'd2); instr_valid = 1'b1; mem_ready = 1'b0;
    step("lim_idle", 3'd0, 10'h0, 2'd0);
    instr_valid = 1'b0;
    for (int i = 0; i < 14; i++) step("lim_wait", 3'd1, MR, 2'd0);
    mem_ready = 1'b1;
    step("lim_fetch", 3'd1, MR | IRW | PCW, 2'd0);
    step("lim_dec",   3'd2, 10'h0, 2'd0);
    step("lim_exec",  3'd3, JMP | PCW, 2'd0);
    step("lim_done",  3'd0, 10'h0, 2'd0);
    chk("lim.timeout", 32'(timeout), 32'd0);

    // Fetch never completes: ERR after 15 wait cycles, sticky until rst
    instr_valid = 1'b1; mem_ready = 1'b0;
    step("to_idle", 3'd0, 10'h0, 2'd0);
    instr_valid = 1'b0;
    for (int i = 0; i < 15; i++) step("to_wait", 3'd1, MR, 2'd0);
    chk("to.timeout", 32'(timeout), 32'd1);
    mem_ready = 1'b1; instr_valid = 1'b1;
    step("to_err0", 3'd6, 10'h0, 2'd0);
    step("to_err1", 3'd6, 10'h0, 2'd0);
    chk("to.timeout_sticky", 32'(timeout), 32'd1);
    instr_valid = 1'b0;
    do_reset("to_rst");

    // Reset in the middle of a LW memory wait: no write-back afterwards
    instr = op(6'd35); instr_valid = 1'b1; mem_ready = 1'b1;
    step("rm_idle", 3'd0, 10'h0, 2'd0);
    instr_valid = 1'b0;
    step("rm_fetch", 3'd1, MR | IRW | PCW, 2'd0);
    step("rm_dec",   3'd2, 10'h0, 2'd0);
    step("rm_exec",  3'd3, ALUS, 2'd0);
    mem_ready = 1'b0;
    step("rm_mem", 3'd4, MR, 2'd0);
    mem_ready = 1'b1;
    do_reset("rm_rst");
    step("rm_after0", 3'd0, 10'h0, 2'd0);
    step("rm_after1", 3'd0, 10'h0, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
